// File: rtl/pattern_sequencer.sv
// ---------------------------------------------------------------------------
// pattern_sequencer
//
// Frame-synchronous controller that picks the test pattern drawn by the VGA
// pixel generator (0 = colour bars, 1 = solid colour, 2 = checker, 3 = black).
//
// The host writes configuration over a valid/ready port into shadow registers.
// The shadow contents commit only on a frame_start cycle, so a pattern change
// can never tear a frame. In auto mode the sequencer cycles through the first
// NUM_PATTERNS patterns, dwelling a programmable number of frames on each.
//
// Register map (cfg_addr):
//   0 CTRL      : data[0]=auto_en, data[2:1]=manual_sel, data[3]=freeze
//   1 DWELL     : data[DWELL_W-1:0], frames per pattern in auto mode (0 acts as 1)
//   2 SOLID_RGB : data[23:0] = {R,G,B} for pattern 1
//   3 reserved  : accepted, ignored
//
// Ports:
//   clk_25         in   25 MHz pixel clock
//   rst_n          in   synchronous reset, active-low
//   frame_start    in   1-cycle pulse at pixel (0,0) of every frame
//   cfg_valid      in   config write request
//   cfg_ready      out  write accepted when cfg_valid && cfg_ready
//   cfg_addr       in   register address
//   cfg_data       in   write data
//   pattern_sel    out  active pattern index
//   solid_rgb      out  colour used by pattern 1
//   pattern_change out  1-cycle pulse when pattern_sel takes a new value
//   frame_cnt      out  frames since reset (0 unless PATSEQ_FRAME_CNT_EN)
//
// Build option:
//   PATSEQ_FRAME_CNT_EN  when defined, frame_cnt counts frame_start pulses
//                        (wrapping modulo 2^16); otherwise it is tied to 0.
// ---------------------------------------------------------------------------
module pattern_sequencer #(
    parameter int NUM_PATTERNS = 4,
    parameter int DWELL_W      = 8,
    parameter int DWELL_RST    = 60
) (
    input  logic        clk_25,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_addr,
    input  logic [23:0] cfg_data,
    output logic [1:0]  pattern_sel,
    output logic [23:0] solid_rgb,
    output logic        pattern_change,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        MANUAL    = 2'd1,
        AUTO      = 2'd2,
        HOLD      = 2'd3
    } state_t;

    localparam logic [1:0] LAST_PAT = 2'(NUM_PATTERNS - 1);

    // Advance threshold: DWELL-1, with a programmed 0 behaving like 1.
    function automatic logic [DWELL_W-1:0] dwell_limit(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    // Dwell counter increment, saturating at all-ones.
    function automatic logic [DWELL_W-1:0] sat_inc(input logic [DWELL_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Next pattern in auto order, wrapping after the last used pattern.
    function automatic logic [1:0] next_pattern(input logic [1:0] s);
        return (s >= LAST_PAT) ? 2'd0 : s + 2'd1;
    endfunction

    // Shadow registers (host side)
    logic               sh_auto_q;
    logic [1:0]         sh_sel_q;
    logic               sh_freeze_q;
    logic [DWELL_W-1:0] sh_dwell_q;
    logic [23:0]        sh_rgb_q;
    logic               ready_en_q;   // low only in the cycle right after reset

    // Active / FSM registers (generator side)
    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [23:0]        rgb_q, rgb_d;
    logic               chg_q, chg_d;

    logic               wr_en;

    // Stalling on frame_start keeps a host write and a commit from ever
    // landing in the same cycle, so the commit always sees a stable shadow.
    assign cfg_ready = ready_en_q && !frame_start;
    assign wr_en     = cfg_valid && cfg_ready;

    // -----------------------------------------------------------------------
    // Shadow register file
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            ready_en_q  <= 1'b0;
            sh_auto_q   <= 1'b0;
            sh_sel_q    <= 2'd0;
            sh_freeze_q <= 1'b0;
            sh_dwell_q  <= DWELL_W'(DWELL_RST);
            sh_rgb_q    <= 24'h000000;
        end else begin
            ready_en_q <= 1'b1;
            if (wr_en) begin
                case (cfg_addr)
                    2'd0: begin
                        sh_auto_q   <= cfg_data[0];
                        sh_sel_q    <= cfg_data[2:1];
                        sh_freeze_q <= cfg_data[3];
                    end
                    2'd1:    sh_dwell_q <= cfg_data[DWELL_W-1:0];
                    2'd2:    sh_rgb_q   <= cfg_data[23:0];
                    default: ;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Frame-boundary next-state logic.
    // The FSM reads the shadow registers directly: on a frame_start cycle the
    // shadow is exactly what is being committed, so this is the
    // "just-committed" configuration without an extra cycle of latency.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rgb_d   = rgb_q;
        chg_d   = 1'b0;
        if (frame_start) begin
            rgb_d = sh_rgb_q;
            if (sh_freeze_q) begin
                // freeze wins over auto_en; selection and counter both hold
                state_d = HOLD;
            end else if (sh_auto_q) begin
                state_d = AUTO;
                if (state_q == AUTO || state_q == HOLD) begin
                    // Running, or resuming from freeze with the count intact.
                    // ">=" also covers DWELL lowered below the current count.
                    if (cnt_q >= dwell_limit(sh_dwell_q)) begin
                        sel_d = next_pattern(sel_q);
                        cnt_d = '0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end else begin
                    // Fresh entry: keep the current pattern, restart the dwell.
                    cnt_d = '0;
                end
            end else begin
                state_d = MANUAL;
                sel_d   = sh_sel_q;
                cnt_d   = '0;
            end
            chg_d = (sel_d != sel_q);
        end
    end

    // -----------------------------------------------------------------------
    // FSM and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            state_q <= WAIT_SYNC;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            rgb_q   <= 24'h000000;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rgb_q   <= rgb_d;
            chg_q   <= chg_d;
        end
    end

    assign pattern_sel    = sel_q;
    assign solid_rgb      = rgb_q;
    assign pattern_change = chg_q;

`ifdef PATSEQ_FRAME_CNT_EN
    logic [15:0] fcnt_q;

    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            fcnt_q <= 16'h0000;
        end else if (frame_start) begin
            fcnt_q <= fcnt_q + 16'd1;
        end
    end

    assign frame_cnt = fcnt_q;
`else
    assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;

    logic        clk_25 = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_addr;
    logic [23:0] cfg_data;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_rgb;
    logic        pattern_change;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;
    int exp_fc = 0;   // frame_start pulses seen since the last reset

    pattern_sequencer dut (
        .clk_25        (clk_25),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .pattern_sel   (pattern_sel),
        .solid_rgb     (solid_rgb),
        .pattern_change(pattern_change),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk_25 = ~clk_25;

    typedef struct {
        logic        fs;
        logic        v;
        logic [1:0]  a;
        logic [23:0] d;
        logic        rdy;
        logic [1:0]  sel;
        logic        chg;
        logic [23:0] rgb;
    } vec_t;

    vec_t tbl[$];

    localparam logic [23:0] ORANGE = 24'hFF8000;

    task automatic add(input logic fs, input logic v, input logic [1:0] a, input logic [23:0] d,
                       input logic rdy, input logic [1:0] sel, input logic chg, input logic [23:0] rgb);
        vec_t r;
        r.fs = fs; r.v = v; r.a = a; r.d = d;
        r.rdy = rdy; r.sel = sel; r.chg = chg; r.rgb = rgb;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_frame_cnt();
`ifdef PATSEQ_FRAME_CNT_EN
        return 16'(exp_fc);
`else
        return 16'h0000;
`endif
    endfunction

    // Apply inputs just after a rising edge, then move to the falling edge for checks.
    task automatic drive(input logic fs, input logic v, input logic [1:0] a, input logic [23:0] d);
        frame_start = fs;
        cfg_valid   = v;
        cfg_addr    = a;
        cfg_data    = d;
        @(negedge clk_25);
    endtask

    task automatic adv();
        @(posedge clk_25);
        if (rst_n && frame_start) exp_fc++;
        #1;
    endtask

    // One frame_start cycle followed by one idle cycle; outputs checked in the idle cycle.
    task automatic frame_chk(input string nm, input logic [1:0] esel, input logic echg, input logic [23:0] ergb);
        drive(1'b1, 1'b0, 2'd0, 24'h0);
        chk({nm, "_rdy_fs"}, 32'(cfg_ready), 32'd0);
        adv();
        drive(1'b0, 1'b0, 2'd0, 24'h0);
        chk({nm, "_sel"}, 32'(pattern_sel), 32'(esel));
        chk({nm, "_chg"}, 32'(pattern_change), 32'(echg));
        chk({nm, "_rgb"}, 32'(solid_rgb), 32'(ergb));
        chk({nm, "_fcnt"}, 32'(frame_cnt), 32'(exp_frame_cnt()));
        adv();
    endtask

    initial begin
        rst_n = 1'b0;
        frame_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_addr = 2'd0;
        cfg_data = 24'h0;

        // Idle frames, no writes
        add(0,0,0,24'h0,      1,0,0,24'h0);
        add(1,0,0,24'h0,      0,0,0,24'h0);
        add(0,0,0,24'h0,      1,0,0,24'h0);
        add(1,0,0,24'h0,      0,0,0,24'h0);
        add(0,0,0,24'h0,      1,0,0,24'h0);
        add(1,0,0,24'h0,      0,0,0,24'h0);
        add(0,0,0,24'h0,      1,0,0,24'h0);
        // Manual select 2 written mid-frame, visible only after the next frame_start
        add(0,1,0,24'h4,      1,0,0,24'h0);
        add(0,0,0,24'h0,      1,0,0,24'h0);
        add(1,0,0,24'h0,      0,0,0,24'h0);
        add(0,0,0,24'h0,      1,2,1,24'h0);
        add(0,0,0,24'h0,      1,2,0,24'h0);
        // Same value rewritten: no pulse
        add(0,1,0,24'h4,      1,2,0,24'h0);
        add(1,0,0,24'h0,      0,2,0,24'h0);
        add(0,0,0,24'h0,      1,2,0,24'h0);
        // SOLID_RGB held across a frame_start: refused there, accepted next cycle
        add(1,1,2,ORANGE,     0,2,0,24'h0);
        add(0,1,2,ORANGE,     1,2,0,24'h0);
        add(0,0,0,24'h0,      1,2,0,24'h0);
        add(1,0,0,24'h0,      0,2,0,24'h0);
        add(0,0,0,24'h0,      1,2,0,ORANGE);
        // DWELL=3, then auto on
        add(0,1,1,24'h3,      1,2,0,ORANGE);
        add(0,1,0,24'h1,      1,2,0,ORANGE);
        add(1,0,0,24'h0,      0,2,0,ORANGE);   // enter auto, count restarts
        add(0,0,0,24'h0,      1,2,0,ORANGE);
        add(1,0,0,24'h0,      0,2,0,ORANGE);
        add(0,0,0,24'h0,      1,2,0,ORANGE);
        add(1,0,0,24'h0,      0,2,0,ORANGE);
        add(0,0,0,24'h0,      1,2,0,ORANGE);
        add(1,0,0,24'h0,      0,2,0,ORANGE);
        add(0,0,0,24'h0,      1,3,1,ORANGE);   // third frame: advance
        add(1,0,0,24'h0,      0,3,0,ORANGE);
        add(0,0,0,24'h0,      1,3,0,ORANGE);
        add(1,0,0,24'h0,      0,3,0,ORANGE);
        add(0,0,0,24'h0,      1,3,0,ORANGE);
        add(1,0,0,24'h0,      0,3,0,ORANGE);
        add(0,0,0,24'h0,      1,0,1,ORANGE);   // wrap 3 -> 0

        // Reset state
        adv();
        adv();
        chk("rst_sel",   32'(pattern_sel),    32'd0);
        chk("rst_rgb",   32'(solid_rgb),      32'd0);
        chk("rst_chg",   32'(pattern_change), 32'd0);
        chk("rst_rdy",   32'(cfg_ready),      32'd0);
        chk("rst_fcnt",  32'(frame_cnt),      32'd0);
        rst_n = 1'b1;
        adv();

        foreach (tbl[i]) begin
            drive(tbl[i].fs, tbl[i].v, tbl[i].a, tbl[i].d);
            chk($sformatf("row%0d_rdy", i),  32'(cfg_ready),      32'(tbl[i].rdy));
            chk($sformatf("row%0d_sel", i),  32'(pattern_sel),    32'(tbl[i].sel));
            chk($sformatf("row%0d_chg", i),  32'(pattern_change), 32'(tbl[i].chg));
            chk($sformatf("row%0d_rgb", i),  32'(solid_rgb),      32'(tbl[i].rgb));
            chk($sformatf("row%0d_fcnt", i), 32'(frame_cnt),      32'(exp_frame_cnt()));
            adv();
        end

        // Auto continues from pattern 0 with count 0
        frame_chk("auto7",  2'd0, 1'b0, ORANGE);
        frame_chk("auto8",  2'd0, 1'b0, ORANGE);
        frame_chk("auto9",  2'd1, 1'b1, ORANGE);
        frame_chk("auto10", 2'd1, 1'b0, ORANGE);   // count now 1

        // Freeze for 10 frames
        drive(1'b0, 1'b1, 2'd0, 24'h9);
        chk("frz_wr_rdy", 32'(cfg_ready), 32'd1);
        adv();
        for (int k = 0; k < 10; k++) frame_chk($sformatf("freeze%0d", k), 2'd1, 1'b0, ORANGE);

        // Unfreeze: count resumes from 1, so the advance comes on the second frame
        drive(1'b0, 1'b1, 2'd0, 24'h1);
        adv();
        frame_chk("resume1", 2'd1, 1'b0, ORANGE);
        frame_chk("resume2", 2'd2, 1'b1, ORANGE);
        frame_chk("to3a",    2'd2, 1'b0, ORANGE);
        frame_chk("to3b",    2'd2, 1'b0, ORANGE);
        frame_chk("to3c",    2'd3, 1'b1, ORANGE);

        // One-cycle reset mid-frame while on pattern 3
        drive(1'b0, 1'b0, 2'd0, 24'h0);
        rst_n = 1'b0;
        @(posedge clk_25);
        exp_fc = 0;
        #1;
        rst_n = 1'b1;
        chk("mrst_sel",  32'(pattern_sel),    32'd0);
        chk("mrst_rgb",  32'(solid_rgb),      32'd0);
        chk("mrst_chg",  32'(pattern_change), 32'd0);
        chk("mrst_rdy",  32'(cfg_ready),      32'd0);
        chk("mrst_fcnt", 32'(frame_cnt),      32'd0);
        adv();

        // Reserved address accepted and ignored; shadow was cleared by reset
        drive(1'b0, 1'b1, 2'd3, 24'hFFFFFF);
        chk("addr3_rdy", 32'(cfg_ready), 32'd1);
        adv();
        frame_chk("post_rst1", 2'd0, 1'b0, 24'h0);
        frame_chk("post_rst2", 2'd0, 1'b0, 24'h0);
        frame_chk("post_rst3", 2'd0, 1'b0, 24'h0);

        // DWELL=0 behaves as 1: advance on every frame after entry
        drive(1'b0, 1'b1, 2'd1, 24'h0);
        adv();
        drive(1'b0, 1'b1, 2'd0, 24'h1);
        adv();
        frame_chk("dw0_entry", 2'd0, 1'b0, 24'h0);
        frame_chk("dw0_step1", 2'd1, 1'b1, 24'h0);
        frame_chk("dw0_step2", 2'd2, 1'b1, 24'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
